// File: rtl/ext_int_ctrl.sv
// External interrupt controller: synchronizes request lines, latches rising edges,
// arbitrates by fixed priority and runs the EE/INT take and rfi restore sequence.
module ext_int_ctrl #(
  parameter int          NUM_IRQ   = 4,
  parameter logic [31:0] VEC_BASE  = 32'h0000_0500,
  parameter int          MSR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_IRQ-1:0]   irq,
  input  logic                 ee,
  input  logic [MSR_WIDTH-1:0] msr_rd,
  input  logic [31:0]          pc_next,
  input  logic                 pipe_bnd,
  input  logic                 rfi,
  output logic                 int_o,
  output logic                 vec_valid,
  output logic [31:0]          vec_pc,
  output logic [NUM_IRQ-1:0]   irq_ack,
  output logic [1:0]           irq_id,
  output logic [31:0]          srr0,
  output logic [MSR_WIDTH-1:0] srr1,
  output logic                 msr_wr,
  output logic [MSR_WIDTH-1:0] msr_wd,
  output logic                 busy,
  output logic [1:0]           dbg_state,
  output logic [NUM_IRQ-1:0]   dbg_pend
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_BND = 2'd1;
  localparam logic [1:0] TAKE     = 2'd2;
  localparam logic [1:0] HANDLER  = 2'd3;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [NUM_IRQ-1:0] s1;
  logic [NUM_IRQ-1:0] s2;
  logic [NUM_IRQ-1:0] s3;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pend;
  logic [1:0]         sel;
  logic [1:0]         sel_q;
  logic               take_go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // A rise landing on the bit being acknowledged keeps it pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= (pend & ~irq_ack) | rise;
  end

  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (pend[i]) sel = 2'(i);
  end

  assign take_go = (state == WAIT_BND) && ee && pipe_bnd;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (|pend && ee) state_nxt = WAIT_BND;
      WAIT_BND: if (!ee) state_nxt = IDLE;
                else if (pipe_bnd) state_nxt = TAKE;
      TAKE:     state_nxt = HANDLER;
      HANDLER:  if (rfi) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The winner is frozen on entry to TAKE so ack, vector and id all agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      vec_pc <= '0;
    end else if (take_go) begin
      sel_q  <= sel;
      vec_pc <= VEC_BASE + {26'd0, sel, 4'd0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srr0   <= '0;
      srr1   <= '0;
      irq_id <= '0;
    end else if (state == TAKE) begin
      srr0   <= pc_next;
      srr1   <= msr_rd;
      irq_id <= sel_q;
    end
  end

  // Handshake: int_o/vec_valid/irq_ack pulse for the single TAKE cycle; the MSR
  // block clears EE on int_o. rfi is honoured only in HANDLER, where it produces a
  // same-cycle msr_wr pulse carrying srr1 back to the MSR.
  always_comb begin
    irq_ack = '0;
    if (state == TAKE) irq_ack[sel_q] = 1'b1;
  end

  assign int_o     = (state == TAKE);
  assign vec_valid = (state == TAKE);
  assign msr_wr    = (state == HANDLER) && rfi;
  assign msr_wd    = srr1;
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign dbg_pend  = pend;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Self-checking bench for ext_int_ctrl: directed scenarios plus randomized request
// sets checked against a priority-order service model.
module tb_ext_int_ctrl;

  localparam logic [31:0] VEC_BASE = 32'h0000_0500;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  irq;
  logic        ee;
  logic [31:0] msr_rd;
  logic [31:0] pc_next;
  logic        pipe_bnd;
  logic        rfi;
  logic        int_o;
  logic        vec_valid;
  logic [31:0] vec_pc;
  logic [3:0]  irq_ack;
  logic [1:0]  irq_id;
  logic [31:0] srr0;
  logic [31:0] srr1;
  logic        msr_wr;
  logic [31:0] msr_wd;
  logic        busy;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_pend;

  int errors = 0;
  int checks = 0;

  ext_int_ctrl #(.NUM_IRQ(4), .VEC_BASE(VEC_BASE), .MSR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .ee(ee), .msr_rd(msr_rd),
    .pc_next(pc_next), .pipe_bnd(pipe_bnd), .rfi(rfi), .int_o(int_o),
    .vec_valid(vec_valid), .vec_pc(vec_pc), .irq_ack(irq_ack), .irq_id(irq_id),
    .srr0(srr0), .srr1(srr1), .msr_wr(msr_wr), .msr_wd(msr_wd), .busy(busy),
    .dbg_state(dbg_state), .dbg_pend(dbg_pend)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // Driver tasks: everything is driven and sampled 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_int(input int max, output int n);
    bit seen;
    seen = 1'b0;
    n = -1;
    for (int i = 1; i <= max; i++) begin
      if (!seen) begin
        tick();
        if (int_o === 1'b1) begin
          seen = 1'b1;
          n = i;
        end
      end
    end
  endtask

  task automatic pulse_rfi();
    rfi = 1'b1;
    tick();
    rfi = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({int_o, vec_valid, vec_pc, irq_ack, irq_id, srr0, srr1, msr_wr, msr_wd,
         busy, dbg_state, dbg_pend} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got int=%b vpc=%h srr0=%h srr1=%h busy=%b st=%0d expected all 0",
               int_o, vec_pc, srr0, srr1, busy, dbg_state);
    end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if ({int_o, busy, dbg_pend, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_release: got int=%b busy=%b pend=%b st=%0d expected 0",
               int_o, busy, dbg_pend, dbg_state);
    end
  endtask

  task automatic test_single();
    ee = 1'b1; pipe_bnd = 1'b1; pc_next = 32'h0000_1234; msr_rd = 32'h0000_8001;
    irq = 4'b0100;
    tick(); tick();
    checks++;
    if (dbg_pend !== 4'b0000) begin
      errors++; $display("FAIL single_pend_early: got %b expected 0000", dbg_pend);
    end
    tick();
    checks++;
    if (dbg_pend !== 4'b0100) begin
      errors++; $display("FAIL single_pend_set: got %b expected 0100", dbg_pend);
    end
    irq = 4'b0000;
    tick();
    checks++;
    if (int_o !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_wait: got int=%b busy=%b expected 0 1", int_o, busy);
    end
    tick();
    checks++;
    if (int_o !== 1'b1 || vec_valid !== 1'b1 || vec_pc !== 32'h0000_0520 || irq_ack !== 4'b0100) begin
      errors++;
      $display("FAIL single_take: got int=%b vv=%b vpc=%h ack=%b expected 1 1 00000520 0100",
               int_o, vec_valid, vec_pc, irq_ack);
    end
    tick();
    checks++;
    if (int_o !== 1'b0 || irq_ack !== 4'b0000 || srr0 !== 32'h1234 || srr1 !== 32'h8001 ||
        irq_id !== 2'd2 || busy !== 1'b1 || dbg_pend !== 4'b0000) begin
      errors++;
      $display("FAIL single_saved: got int=%b ack=%b srr0=%h srr1=%h id=%0d busy=%b pend=%b",
               int_o, irq_ack, srr0, srr1, irq_id, busy, dbg_pend);
    end
    repeat (3) tick();
    rfi = 1'b1;
    #1;
    checks++;
    if (msr_wr !== 1'b1 || msr_wd !== 32'h0000_8001) begin
      errors++; $display("FAIL rfi_restore: got wr=%b wd=%h expected 1 00008001", msr_wr, msr_wd);
    end
    tick();
    rfi = 1'b0;
    #1;
    checks++;
    if (msr_wr !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rfi_after: got wr=%b busy=%b expected 0 0", msr_wr, busy);
    end
  endtask

  task automatic test_priority();
    int n;
    ee = 1'b1; pipe_bnd = 1'b1;
    irq = 4'b1010;
    tick(); tick();
    irq = 4'b0000;
    wait_int(10, n);
    checks++;
    if (n < 0 || vec_pc !== 32'h0000_0510 || irq_ack !== 4'b0010) begin
      errors++; $display("FAIL prio_first: got n=%0d vpc=%h ack=%b expected 00000510 0010", n, vec_pc, irq_ack);
    end
    tick(); tick();
    pulse_rfi();
    wait_int(10, n);
    checks++;
    if (n !== 2 || vec_pc !== 32'h0000_0530 || irq_ack !== 4'b1000) begin
      errors++; $display("FAIL prio_second: got gap=%0d vpc=%h ack=%b expected 2 00000530 1000", n, vec_pc, irq_ack);
    end
    tick();
    pulse_rfi();
    tick();
  endtask

  task automatic test_ee_gating();
    bit bad;
    ee = 1'b0; pipe_bnd = 1'b1;
    irq = 4'b0001;
    tick(); tick();
    irq = 4'b0000;
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (int_o !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || dbg_pend !== 4'b0001) begin
      errors++; $display("FAIL ee_gate: got bad=%b pend=%b expected 0 0001", bad, dbg_pend);
    end
    ee = 1'b1;
    tick();
    checks++;
    if (int_o !== 1'b0 || dbg_state !== 2'd1) begin
      errors++; $display("FAIL ee_first: got int=%b st=%0d expected 0 1", int_o, dbg_state);
    end
    tick();
    checks++;
    if (int_o !== 1'b1 || vec_pc !== 32'h0000_0500 || irq_ack !== 4'b0001) begin
      errors++; $display("FAIL ee_take: got int=%b vpc=%h ack=%b expected 1 00000500 0001", int_o, vec_pc, irq_ack);
    end
    tick();
    pulse_rfi();
    tick();
  endtask

  task automatic test_boundary();
    bit bad;
    int n;
    ee = 1'b1; pipe_bnd = 1'b0;
    irq = 4'b0010;
    tick(); tick();
    irq = 4'b0000;
    repeat (3) tick();
    bad = 1'b0;
    repeat (10) begin
      tick();
      if (int_o !== 1'b0 || dbg_state !== 2'd1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL bnd_hold: got st=%0d int=%b expected st 1 int 0", dbg_state, int_o);
    end
    rfi = 1'b1;
    #1;
    checks++;
    if (msr_wr !== 1'b0) begin
      errors++; $display("FAIL rfi_stray_wait: got wr=%b expected 0", msr_wr);
    end
    tick();
    rfi = 1'b0;
    ee = 1'b0;
    tick();
    checks++;
    if (dbg_state !== 2'd0 || busy !== 1'b0 || dbg_pend !== 4'b0010) begin
      errors++; $display("FAIL bnd_abort: got st=%0d busy=%b pend=%b expected 0 0 0010", dbg_state, busy, dbg_pend);
    end
    ee = 1'b1; pipe_bnd = 1'b1;
    wait_int(10, n);
    checks++;
    if (n !== 2 || vec_pc !== 32'h0000_0510 || irq_ack !== 4'b0010) begin
      errors++; $display("FAIL bnd_take: got n=%0d vpc=%h ack=%b expected 2 00000510 0010", n, vec_pc, irq_ack);
    end
    tick();
    pulse_rfi();
    tick();
  endtask

  task automatic test_stray_rfi();
    ee = 1'b0;
    rfi = 1'b1;
    #1;
    checks++;
    if (msr_wr !== 1'b0) begin
      errors++; $display("FAIL rfi_stray_idle: got wr=%b expected 0", msr_wr);
    end
    tick();
    rfi = 1'b0;
    checks++;
    if (dbg_state !== 2'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rfi_stray_state: got st=%0d busy=%b expected 0 0", dbg_state, busy);
    end
    ee = 1'b1;
  endtask

  // Scoreboard: a random request set must be serviced in ascending index order.
  task automatic test_back_to_back();
    logic [3:0]  mask;
    logic [1:0]  exp_q[$];
    logic [1:0]  id;
    logic [31:0] pc;
    logic [31:0] msr;
    bit          first;
    int          n;
    ee = 1'b1; pipe_bnd = 1'b1;
    for (int it = 0; it < 8; it++) begin
      mask = 4'($urandom_range(1, 15));
      exp_q.delete();
      for (int b = 0; b < 4; b++) if (mask[b]) exp_q.push_back(2'(b));
      irq = mask;
      tick(); tick();
      irq = 4'b0000;
      first = 1'b1;
      while (exp_q.size() > 0) begin
        pc = $urandom; msr = $urandom;
        pc_next = pc; msr_rd = msr;
        id = exp_q.pop_front();
        wait_int(12, n);
        checks++;
        if (n < 0 || (!first && n != 2)) begin
          errors++; $display("FAIL b2b_gap: got %0d expected %s", n, first ? "take" : "2");
        end
        checks++;
        if (vec_pc !== VEC_BASE + 32'(id) * 16 || irq_ack !== 4'(1 << id)) begin
          errors++; $display("FAIL b2b_vec: got vpc=%h ack=%b expected id %0d", vec_pc, irq_ack, id);
        end
        tick();
        checks++;
        if (srr0 !== pc || srr1 !== msr || irq_id !== id) begin
          errors++; $display("FAIL b2b_save: got srr0=%h srr1=%h id=%0d expected %h %h %0d",
                             srr0, srr1, irq_id, pc, msr, id);
        end
        repeat ($urandom_range(0, 3)) tick();
        rfi = 1'b1;
        #1;
        checks++;
        if (msr_wr !== 1'b1 || msr_wd !== msr) begin
          errors++; $display("FAIL b2b_rfi: got wr=%b wd=%h expected 1 %h", msr_wr, msr_wd, msr);
        end
        tick();
        rfi = 1'b0;
        first = 1'b0;
      end
      repeat (4) tick();
      checks++;
      if (dbg_pend !== 4'b0000 || busy !== 1'b0) begin
        errors++; $display("FAIL b2b_drain: got pend=%b busy=%b expected 0000 0", dbg_pend, busy);
      end
    end
  endtask

  task automatic test_collision_reset();
    bit bad;
    ee = 1'b1; pipe_bnd = 1'b1;
    irq = 4'b0001;
    tick();
    irq = 4'b0000;
    tick(); tick();
    irq = 4'b0001;
    tick(); tick();
    checks++;
    if (int_o !== 1'b1 || irq_ack !== 4'b0001) begin
      errors++; $display("FAIL coll_take: got int=%b ack=%b expected 1 0001", int_o, irq_ack);
    end
    tick();
    checks++;
    if (dbg_pend !== 4'b0001 || dbg_state !== 2'd3) begin
      errors++; $display("FAIL coll_pend: got pend=%b st=%0d expected 0001 3", dbg_pend, dbg_state);
    end
    irq = 4'b0000;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({int_o, vec_valid, vec_pc, irq_ack, irq_id, srr0, srr1, msr_wr, msr_wd,
         busy, dbg_state, dbg_pend} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got vpc=%h srr0=%h busy=%b st=%0d pend=%b expected all 0",
               vec_pc, srr0, busy, dbg_state, dbg_pend);
    end
    tick();
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (12) begin
      tick();
      if (int_o !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL reset_quiet: got int_o or busy high, expected 0");
    end
  endtask

  initial begin
    rst_n = 1'b0; irq = '0; ee = 1'b0; msr_rd = '0; pc_next = '0; pipe_bnd = 1'b0; rfi = 1'b0;
    repeat (2) tick();
    test_reset();
    test_single();
    test_priority();
    test_ee_gating();
    test_boundary();
    test_stray_rfi();
    test_back_to_back();
    test_collision_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ext_int_ctrl.md
Name: ext_int_ctrl

Overview:
- External interrupt controller on the requesting side of the MSR EE/INT handshake.
- Captures external interrupt requests and arbitrates among them.
- When MSR.EE is set and the pipeline is at an instruction boundary, it fires a one-cycle INT to the MSR block (which clears EE), saves the return state into SRR0/SRR1 and redirects fetch to a per-source vector.
- On rfi it hands SRR1 back to the MSR write port and returns to idle.

Parameters:
- NUM_IRQ, 4, number of external request lines; index 0 is highest priority.
- VEC_BASE, 32'h0000_0500, vector address of source 0; source i vectors to VEC_BASE + 16*i.
- MSR_WIDTH, 32, MSR width; bit 16 = EE, numbered MSB-first [0:MSR_WIDTH-1].

Ports:
- clk  in  1  single clock for the block.
- rst_n  in  1  asynchronous active-low reset.
- irq  in  NUM_IRQ  external requests; asynchronous, rising-edge significant.
- ee  in  1  current MSR.EE from the MSR block.
- msr_rd  in  MSR_WIDTH  current MSR value, saved into SRR1.
- pc_next  in  32  address of the next unexecuted instruction, saved into SRR0.
- pipe_bnd  in  1  pipeline drained, at an instruction boundary.
- rfi  in  1  rfi retired (1-cycle pulse).
- int_o  out  1  drives MSR INT; 1-cycle pulse.
- vec_valid  out  1  fetch redirect strobe; 1 cycle, coincident with int_o.
- vec_pc  out  32  redirect target; valid when vec_valid=1.
- irq_ack  out  NUM_IRQ  one-hot acknowledge pulse, coincident with int_o.
- irq_id  out  2  id of the source being serviced; held until the next take.
- srr0  out  32  saved return address; the rfi target.
- srr1  out  MSR_WIDTH  saved MSR.
- msr_wr  out  1  MSR restore write enable; 1-cycle pulse on rfi.
- msr_wd  out  MSR_WIDTH  restore data, equal to srr1.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: every register and output is 0, state = IDLE. Asserting reset mid-service aborts it and drops all pending requests.
- Input synchronizer: per-line 2-flop synchronizer s1→s2, plus delay flop s3.
- Edge detect: rise[i] = s2[i] & ~s3[i]. The pending bit is set on rise. A request held high counts once; a new request needs a low period of at least 2 cycles.
- Pending set latency: irq[i] rising before edge k → pend[i]=1 after edge k+2.
- Pending set/clear collision: if set (rise) and clear (ack) hit the same bit in the same cycle, set wins and the bit stays pending.
- Arbitration: fixed priority, lowest index wins. The selection is frozen in the TAKE cycle.
- IDLE → WAIT_BND when |pend && ee. Otherwise remain in IDLE.
- WAIT_BND:
  - ee=0 (software cleared EE) → back to IDLE with nothing taken and pend unchanged.
  - ee=1 && pipe_bnd=1 → TAKE.
  - Otherwise wait.
- TAKE, exactly 1 cycle, with id = highest-priority pending source:
  - int_o=1, vec_valid=1, vec_pc = VEC_BASE + (id<<4), irq_ack[id]=1.
  - At the clock edge: srr0<=pc_next, srr1<=msr_rd, irq_id<=id, pend[id] cleared.
  - Then → HANDLER.
- HANDLER:
  - Waits for rfi; no nesting. New requests accumulate in pend.
  - On rfi: msr_wr=1 and msr_wd=srr1 in the same cycle (combinational from state & rfi), then → IDLE.
- rfi received in any state other than HANDLER is ignored: no msr_wr, no state change.
- Back-to-back service: after rfi restores EE=1, a still-pending source is taken with no extra gap beyond IDLE→WAIT_BND→TAKE (minimum 2 cycles from the rfi cycle to int_o).
- Output timing: int_o, vec_valid and irq_ack are decoded from the state flop. They never stay high longer than 1 cycle.
- vec_pc: holds its value outside TAKE and is 0 after reset.

Test Plan:
1. Single request, EE=1, pipe_bnd=1, pc_next=32'h0000_1234, msr_rd=32'h0000_8001; irq[2] rises before edge 0 → pend[2] after edge 2, int_o=1 in the cycle after edge 4, vec_pc=32'h0000_0520, irq_ack=4'b0100. After that edge: srr0=32'h1234, srr1=32'h8001, irq_id=2, busy=1.
2. Priority: irq[3] and irq[1] rise in the same cycle, EE=1 → irq[1] taken first (vec_pc=32'h510). After rfi with ee=1 → irq[3] taken (vec_pc=32'h530); rfi-to-int_o is 2 cycles.
3. EE gating: irq[0] pending with ee=0 for 20 cycles → int_o stays 0, busy=0. ee→1 → int_o 2 cycles later with vec_pc=32'h500.
4. Boundary wait and abort: pending with ee=1 and pipe_bnd=0 → state holds in WAIT_BND. Drop ee → IDLE, pend kept. Then ee=1 and pipe_bnd=1 → normal take.
5. rfi handling: stray rfi in IDLE → msr_wr stays 0. rfi in HANDLER with srr1=32'h0000_8001 → msr_wr=1 and msr_wd=32'h0000_8001 for exactly 1 cycle, busy→0.
6. Collision and reset: new rise on irq[0] in its own TAKE cycle → pend[0] stays 1 afterwards. rst_n low during HANDLER → all outputs 0, pend=0, state IDLE; no int_o after release until a new edge.
